// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-stage control-transfer sequencer:
// state encoding and the per-operation beat count.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALL = 3'd1,
    ST_RET  = 3'd2,
    ST_RTI  = 3'd3,
    ST_INT  = 3'd4
  } state_e;

  // Number of stack beats an operation occupies. RTI and INT move the
  // flags word in addition to the PC words.
  function automatic int unsigned op_len(input state_e st, input int unsigned beats);
    int unsigned len;
    case (st)
      ST_RTI, ST_INT: len = beats + 32'd1;
      default:        len = beats;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_seq_control_beat_counter.sv
// Generic beat counter for multi-cycle stages: counts while enabled,
// flags the final beat and wraps to zero after it.
module beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign last = (cnt_q == last_val);

  // Next count: clear wins, otherwise advance and wrap after the last beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_seq_control.sv
// MEM-stage sequencer for CALL/RET/RTI and interrupt entry. Moves a
// multi-word PC (and flags for RTI/INT) one stack word per cycle while
// stalling the pipeline, then issues a single jump pulse.
module mem_seq_control
  import mem_seq_pkg::*;
#(
  parameter int BEATS     = 2,
  parameter int INT_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         rti,
  input  logic                         int_req,
  input  logic                         int_en,
  output logic                         extend,
  output logic                         busy,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic                         sp_inc,
  output logic                         sp_dec,
  output logic [$clog2(BEATS+1)-1:0]   word_sel,
  output logic                         flags_sel,
  output logic                         flags_restore,
  output logic                         jump,
  output logic                         jump_vec,
  output logic                         int_ack
);

  localparam int CNT_W = $clog2(BEATS+1);
  localparam logic [CNT_W-1:0] BEATS_M1 = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FLAGS_BEAT = CNT_W'(BEATS);

  state_e           state_q;
  state_e           state_d;
  state_e           instr_op_s;
  logic             pending_q;
  logic             pending_d;
  logic [CNT_W-1:0] beat_s;
  logic [CNT_W-1:0] last_val_s;
  logic             last_s;
  logic             in_op_s;
  logic             take_int_s;
  logic             instr_s;

  assign in_op_s    = (state_q != ST_IDLE);
  assign last_val_s = CNT_W'(op_len(state_q, int'(BEATS)) - 32'd1);

  beat_counter #(
    .W (CNT_W)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_op_s),
    .en       (in_op_s),
    .last_val (last_val_s),
    .cnt      (beat_s),
    .last     (last_s)
  );

  // Accept logic in IDLE, per-beat strobe decode in the op states.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | int_req;
    extend        = 1'b0;
    busy          = 1'b0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    word_sel      = '0;
    flags_sel     = 1'b0;
    flags_restore = 1'b0;
    jump          = 1'b0;
    jump_vec      = 1'b0;
    int_ack       = 1'b0;
    take_int_s    = (pending_q | int_req) & int_en;
    instr_s       = call | ret | rti;

    if (rti) begin
      instr_op_s = ST_RTI;
    end else if (ret) begin
      instr_op_s = ST_RET;
    end else if (call) begin
      instr_op_s = ST_CALL;
    end else begin
      instr_op_s = ST_IDLE;
    end

    case (state_q)
      ST_IDLE: begin
        // Reset gating keeps every output low while rst is asserted.
        if (rst && take_int_s && ((INT_FIRST != 0) || !instr_s)) begin
          state_d   = ST_INT;
          pending_d = 1'b0;
          int_ack   = 1'b1;
          extend    = 1'b1;
        end else if (rst && instr_s) begin
          state_d = instr_op_s;
          extend  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALL: begin
        busy     = 1'b1;
        extend   = !last_s;
        mem_we   = 1'b1;
        sp_dec   = 1'b1;
        word_sel = beat_s;
      end
      ST_RET: begin
        busy     = 1'b1;
        extend   = !last_s;
        mem_re   = 1'b1;
        sp_inc   = 1'b1;
        word_sel = BEATS_M1 - beat_s;
        jump     = last_s;
      end
      ST_INT: begin
        busy     = 1'b1;
        extend   = !last_s;
        mem_we   = 1'b1;
        sp_dec   = 1'b1;
        jump     = last_s;
        jump_vec = last_s;
        if (beat_s == '0) begin
          flags_sel = 1'b1;
        end else begin
          word_sel = beat_s - CNT_W'(1);
        end
      end
      ST_RTI: begin
        busy   = 1'b1;
        extend = !last_s;
        mem_re = 1'b1;
        sp_inc = 1'b1;
        if (beat_s == FLAGS_BEAT) begin
          flags_sel     = 1'b1;
          flags_restore = 1'b1;
          jump          = 1'b1;
        end else begin
          word_sel = BEATS_M1 - beat_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_op_s && last_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State and pending-interrupt registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_mem_seq_control.sv
// Directed table-driven bench for mem_seq_control across four
// configurations: (BEATS,INT_FIRST) = (2,0), (2,1), (4,0), (1,0).
module tb_mem_seq_control;

  // Output bit positions in the packed compare word.
  localparam logic [10:0] X_EXT = 11'h400;
  localparam logic [10:0] X_BSY = 11'h200;
  localparam logic [10:0] X_RE  = 11'h100;
  localparam logic [10:0] X_WE  = 11'h080;
  localparam logic [10:0] X_INC = 11'h040;
  localparam logic [10:0] X_DEC = 11'h020;
  localparam logic [10:0] X_FS  = 11'h010;
  localparam logic [10:0] X_FR  = 11'h008;
  localparam logic [10:0] X_J   = 11'h004;
  localparam logic [10:0] X_JV  = 11'h002;
  localparam logic [10:0] X_ACK = 11'h001;
  localparam logic [10:0] X_NONE = 11'h000;

  // Input bits: {call, ret, rti, int_req, int_en}
  localparam logic [4:0] I_CALL = 5'b10000;
  localparam logic [4:0] I_RET  = 5'b01000;
  localparam logic [4:0] I_RTI  = 5'b00100;
  localparam logic [4:0] I_IRQ  = 5'b00010;
  localparam logic [4:0] I_IEN  = 5'b00001;
  localparam logic [4:0] I_NONE = 5'b00000;

  typedef struct {
    int          dut;
    logic [4:0]  in;
    logic [10:0] exp;
    logic [3:0]  ws;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  din  [4];
  wire  [10:0] dout [4];
  wire  [3:0]  dws  [4];

  int checks;
  int errors;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int B  = (g == 2) ? 4 : ((g == 3) ? 1 : 2);
    localparam int IF = (g == 1) ? 1 : 0;
    localparam int W  = $clog2(B + 1);
    logic         ext, bsy, re, we, inc, dec, fs, fr, jp, jv, ack;
    logic [W-1:0] ws;

    mem_seq_control #(
      .BEATS     (B),
      .INT_FIRST (IF)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .call          (din[g][4]),
      .ret           (din[g][3]),
      .rti           (din[g][2]),
      .int_req       (din[g][1]),
      .int_en        (din[g][0]),
      .extend        (ext),
      .busy          (bsy),
      .mem_re        (re),
      .mem_we        (we),
      .sp_inc        (inc),
      .sp_dec        (dec),
      .word_sel      (ws),
      .flags_sel     (fs),
      .flags_restore (fr),
      .jump          (jp),
      .jump_vec      (jv),
      .int_ack       (ack)
    );

    assign dout[g] = {ext, bsy, re, we, inc, dec, fs, fr, jp, jv, ack};
    assign dws[g]  = 4'(ws);
  end

  task automatic check(input int d, input logic [10:0] e, input logic [3:0] w, input string nm);
    checks++;
    if (dout[d] !== e || dws[d] !== w) begin
      errors++;
      $display("FAIL %s dut%0d got out=%b ws=%0d want out=%b ws=%0d", nm, d, dout[d], dws[d], e, w);
    end
  endtask

  function automatic void add(input int d, input logic [4:0] i, input logic [10:0] e,
                              input logic [3:0] w, input string nm);
    vec_t v;
    v.dut = d; v.in = i; v.exp = e; v.ws = w; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) din[k] = I_NONE;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();

    // RET, BEATS=2 (dut0)
    add(0, I_RET, X_EXT,                             4'd0, "ret_start");
    add(0, I_RET, X_BSY|X_EXT|X_RE|X_INC,            4'd1, "ret_b0");
    add(0, I_RET, X_BSY|X_RE|X_INC|X_J,              4'd0, "ret_b1_jump");
    add(0, I_NONE, X_NONE,                           4'd0, "ret_idle");
    // INT entry, BEATS=2 (dut0)
    add(0, I_IRQ|I_IEN, X_EXT|X_ACK,                 4'd0, "int_ack");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC|X_FS,       4'd0, "int_flags");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC,            4'd0, "int_pc0");
    add(0, I_IEN, X_BSY|X_WE|X_DEC|X_J|X_JV,         4'd1, "int_pc1_jump");
    add(0, I_IEN, X_NONE,                            4'd0, "int_pending_clr");
    // RTI, BEATS=4 (dut2)
    add(2, I_RTI, X_EXT,                             4'd0, "rti_start");
    add(2, I_RTI, X_BSY|X_EXT|X_RE|X_INC,            4'd3, "rti_b0");
    add(2, I_RTI, X_BSY|X_EXT|X_RE|X_INC,            4'd2, "rti_b1");
    add(2, I_RTI, X_BSY|X_EXT|X_RE|X_INC,            4'd1, "rti_b2");
    add(2, I_RTI, X_BSY|X_EXT|X_RE|X_INC,            4'd0, "rti_b3");
    add(2, I_RTI, X_BSY|X_RE|X_INC|X_FS|X_FR|X_J,    4'd0, "rti_flags_jump");
    add(2, I_NONE, X_NONE,                           4'd0, "rti_idle");
    // CALL vs INT, instruction first (dut0)
    add(0, I_CALL|I_IRQ|I_IEN, X_EXT,                4'd0, "if0_call_start");
    add(0, I_CALL|I_IEN, X_BSY|X_EXT|X_WE|X_DEC,     4'd0, "if0_call_b0");
    add(0, I_CALL|I_IEN, X_BSY|X_WE|X_DEC,           4'd1, "if0_call_b1");
    add(0, I_IEN, X_EXT|X_ACK,                       4'd0, "if0_int_ack");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC|X_FS,       4'd0, "if0_int_flags");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC,            4'd0, "if0_int_pc0");
    add(0, I_IEN, X_BSY|X_WE|X_DEC|X_J|X_JV,         4'd1, "if0_int_jump");
    add(0, I_IEN, X_NONE,                            4'd0, "if0_idle");
    // CALL vs INT, interrupt first (dut1)
    add(1, I_CALL|I_IRQ|I_IEN, X_EXT|X_ACK,          4'd0, "if1_int_ack");
    add(1, I_CALL|I_IEN, X_BSY|X_EXT|X_WE|X_DEC|X_FS, 4'd0, "if1_int_flags");
    add(1, I_CALL|I_IEN, X_BSY|X_EXT|X_WE|X_DEC,     4'd0, "if1_int_pc0");
    add(1, I_CALL|I_IEN, X_BSY|X_WE|X_DEC|X_J|X_JV,  4'd1, "if1_int_jump");
    add(1, I_CALL|I_IEN, X_EXT,                      4'd0, "if1_call_start");
    add(1, I_CALL|I_IEN, X_BSY|X_EXT|X_WE|X_DEC,     4'd0, "if1_call_b0");
    add(1, I_CALL|I_IEN, X_BSY|X_WE|X_DEC,           4'd1, "if1_call_b1");
    add(1, I_IEN, X_NONE,                            4'd0, "if1_idle");
    // Masked interrupt held pending until enabled (dut0)
    add(0, I_IRQ, X_NONE,                            4'd0, "mask_req");
    for (int k = 0; k < 4; k++) add(0, I_NONE, X_NONE, 4'd0, "mask_hold");
    add(0, I_IEN, X_EXT|X_ACK,                       4'd0, "mask_ack");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC|X_FS,       4'd0, "mask_flags");
    add(0, I_IEN, X_BSY|X_EXT|X_WE|X_DEC,            4'd0, "mask_pc0");
    add(0, I_IEN, X_BSY|X_WE|X_DEC|X_J|X_JV,         4'd1, "mask_jump");
    add(0, I_IEN, X_NONE,                            4'd0, "mask_idle");
    // RET with BEATS=1 (dut3)
    add(3, I_RET, X_EXT,                             4'd0, "b1_ret_start");
    add(3, I_RET, X_BSY|X_RE|X_INC|X_J,              4'd0, "b1_ret_jump");
    add(3, I_NONE, X_NONE,                           4'd0, "b1_idle");

    // Reset state of every configuration
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) check(d, X_NONE, 4'd0, "reset_state");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < vecs.size(); n++) begin
      clear_inputs();
      din[vecs[n].dut] = vecs[n].in;
      @(negedge clk);
      check(vecs[n].dut, vecs[n].exp, vecs[n].ws, vecs[n].name);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of an RTI, with a masked request pending
    clear_inputs();
    din[2] = I_RTI | I_IRQ;
    @(negedge clk);
    check(2, X_EXT, 4'd0, "rst_rti_start");
    @(posedge clk);
    #1 din[2] = I_RTI;
    @(negedge clk);
    check(2, X_BSY|X_EXT|X_RE|X_INC, 4'd3, "rst_rti_b0");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check(2, X_NONE, 4'd0, "rst_async_clear");
    @(negedge clk);
    check(2, X_NONE, 4'd0, "rst_held_rti");
    @(posedge clk);
    #1 rst = 1'b1;
    din[2] = I_IEN;
    @(negedge clk);
    check(2, X_NONE, 4'd0, "rst_pending_clr");
    @(posedge clk);
    #1;
    @(negedge clk);
    check(2, X_NONE, 4'd0, "rst_no_jump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_seq_control.md
Name: mem_seq_control

Overview:
- Parametrised multi-cycle memory-stage sequencer for stack-based control transfers: CALL, RET and RTI instructions, plus hardware interrupt entry.
- Sits beside the MEM stage. It stalls the pipeline (`extend`) while a multi-word PC and flags transfer runs, one word per cycle.
- It drives stack-pointer and memory strobes, word/flags selects, and a final `jump` pulse.
- Adds three things to the earlier two-beat RET/INT control: configurable PC word count, CALL/RTI support, and a latched, maskable interrupt with selectable priority.

Parameters:
- `BEATS`, default 2, number of data-bus words per PC (range 1..8).
- `INT_FIRST`, default 0. 1 = a pending interrupt wins over a same-cycle instruction request; 0 = the instruction wins.
- `CNT_W`: localparam `$clog2(BEATS+1)`, not overridable.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `call` input 1: MEM-stage instruction is CALL (push PC).
- `ret` input 1: MEM-stage instruction is RET (pop PC).
- `rti` input 1: MEM-stage instruction is RTI (pop PC, then pop flags).
- `int_req` input 1: external interrupt request, pulse or level.
- `int_en` input 1: interrupt enable (flags I bit).
- `extend` output 1: stall upstream stages and hold the MEM stage.
- `busy` output 1: sequencer is not IDLE.
- `mem_re` output 1: stack read this cycle.
- `mem_we` output 1: stack write this cycle.
- `sp_inc` output 1: SP += 1 word at the end of this cycle (pop).
- `sp_dec` output 1: SP -= 1 word at the end of this cycle (push).
- `word_sel` output CNT_W: PC word index for this beat.
- `flags_sel` output 1: this beat transfers flags, not a PC word.
- `flags_restore` output 1: load flags from memory data.
- `jump` output 1: one-cycle pulse to redirect the PC.
- `jump_vec` output 1: valid with `jump`. 1 = target is the interrupt vector; 0 = target is the popped PC.
- `int_ack` output 1: one-cycle pulse when an interrupt is accepted.

Behaviour:
- States: IDLE, CALL, RET, RTI, INT. Beat counter `beat` is CNT_W wide.
- Op length L:
  - CALL and RET: L = BEATS.
  - RTI and INT: L = BEATS+1.
  - Last beat is beat == L-1.
- Reset (`rst` = 0, at any time, including mid-operation):
  - state = IDLE, beat = 0, pending = 0.
  - Every output is 0 and `word_sel` = 0.
  - Any partial transfer is abandoned; no `jump` is issued.
- Pending interrupt:
  - `pending` is set on a clk edge where `int_req` = 1.
  - It is cleared on the edge where the interrupt is accepted.
  - Requests arriving while pending = 1 merge into the same pending interrupt.
  - If `int_en` = 0, `pending` holds indefinitely.
- Accept, evaluated in IDLE only:
  - `take_int` = (pending | int_req) & int_en.
  - Instruction priority: rti > ret > call.
  - If `INT_FIRST` = 0, the instruction beats `take_int`; if 1, `take_int` beats the instruction.
  - The losing interrupt stays pending. A losing instruction is still present after the interrupt returns, so it is re-sampled then.
- Start cycle (IDLE with an accepted request):
  - `extend` = 1.
  - `int_ack` = 1 if the interrupt was accepted.
  - Next state is the chosen op with beat = 0.
- Requests outside IDLE: `call`, `ret`, `rti` and `int_req` do not start anything. `int_req` still sets `pending`.
- Each op-state cycle:
  - `busy` = 1.
  - `extend` = 1 except on the last beat.
  - `beat` increments each cycle; after the last beat, state returns to IDLE and beat = 0.
- Per-op beat mapping:
  - CALL: `mem_we` = 1 and `sp_dec` = 1 every beat; `word_sel` = beat; no `jump`.
  - RET: `mem_re` = 1 and `sp_inc` = 1 every beat; `word_sel` = BEATS-1-beat (mirror of push order); `jump` = 1 and `jump_vec` = 0 on the last beat.
  - INT:
    - Beat 0: `flags_sel` = 1, `mem_we` = 1, `sp_dec` = 1.
    - Beats 1..BEATS: PC words with `word_sel` = beat-1, `mem_we` = 1, `sp_dec` = 1.
    - Last beat: `jump` = 1, `jump_vec` = 1.
  - RTI:
    - Beats 0..BEATS-1: pop PC words as RET does.
    - Last beat: `flags_sel` = 1, `mem_re` = 1, `sp_inc` = 1, `flags_restore` = 1, `jump` = 1, `jump_vec` = 0.
- Total MEM-stage occupancy of an instruction is L+1 cycles. Because `extend` drops on the last beat, the instruction leaves with `jump`, and IDLE never re-samples the same request.
- `BEATS` = 1: RET is a single beat, so `extend` is high only in the start cycle and `jump` comes on beat 0.
- Outputs are combinational from state, beat and the IDLE-cycle accept logic. Only state, beat and pending are registered.

Decomposition:
- Shared package `mem_seq_pkg` holds:
  - State encoding: IDLE=3'd0, CALL=3'd1, RET=3'd2, RTI=3'd3, INT=3'd4.
  - Op-length function `op_len(state, BEATS)`.
- Natural sub-module: `beat_counter`, a CNT_W-bit counter with clear, enable and last-beat compare, reused by future multi-cycle stages.

Test Plan:
- BEATS=2, `ret` pulse at cycle N → `extend` high N..N+1; `mem_re`/`sp_inc` at N+1 and N+2 with `word_sel` 1 then 0; `jump`=1, `jump_vec`=0 at N+2; IDLE at N+3.
- BEATS=2, `int_req`=1 with `int_en`=1 at N → `int_ack` at N; `flags_sel`+`mem_we` at N+1; `word_sel` 0,1 at N+2, N+3; `jump_vec`=1 at N+3; 3 `sp_dec`.
- BEATS=4, `rti` → 4 PC pops (`word_sel` 3,2,1,0) then a flags pop with `flags_restore`=1 and `jump`=1 on beat 4; `extend` high for 5 cycles.
- INT_FIRST=0, `call` and `int_req` same cycle → CALL runs 2 beats with no `jump`; `int_ack` in the cycle after CALL's last beat.
- INT_FIRST=1, same stimulus → INT first.
- `int_req` pulse with `int_en`=0 → no `int_ack`; raise `int_en` 5 cycles later → `int_ack` the same cycle.
- `rst` low mid-RTI beat 1 → all outputs 0 asynchronously; after release, IDLE with pending=0 and no `jump`.
